v6_filter_seq: RTL and testbench

Sequencer and event controller for the v6 shaping filter. Owns the filter's reset, waits out its pipeline settle time, then watches the filtered stream for threshold crossings. For each pulse it captures peak amplitude, peak timestamp and width, and hands the event to readout over a valid/ready port. Sits between the v6 filter output and the readout FIFO, one instance per ADC channel.

---
 rtl/v6_filter_seq.sv | 198 +++++++++++++++++++
 tb/tb_v6_filter_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/v6_filter_seq.sv
// v6_filter_seq
//   Sequencer and event controller for one v6 shaping-filter channel.
//   Holds the filter in reset while idle, waits out the filter settle time,
//   then detects threshold crossings on the filtered stream. For each pulse
//   it captures the peak, the timestamp of the first peak sample and the
//   width, and presents the event on a valid/ready port.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       run request; low returns the block to IDLE
//   i_threshold    signed trigger level
//   i_filt_data    signed filter sample, one per clock
//   o_filt_rst_n   registered active-low reset to the filter
//   o_evt_valid    event register holds an event
//   i_evt_ready    readout accepts the event
//   o_evt_peak     peak sample of the pulse
//   o_evt_time     timestamp of the first sample equal to the peak
//   o_evt_width    number of samples above threshold
//   o_dropped_cnt  events lost to backpressure (saturating)
//   o_state        IDLE=0 SETTLE=1 ARMED=2 PULSE=3 HOLD=4
module v6_filter_seq #(
  parameter int DATA_W           = 16,
  parameter int TS_W             = 32,
  parameter int SETTLE_CYCLES    = 64,
  parameter int HOLDOFF_CYCLES   = 16,
  parameter int MAX_PULSE_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic signed [DATA_W-1:0] i_threshold,
  input  logic signed [DATA_W-1:0] i_filt_data,
  output logic                     o_filt_rst_n,
  output logic                     o_evt_valid,
  input  logic                     i_evt_ready,
  output logic signed [DATA_W-1:0] o_evt_peak,
  output logic [TS_W-1:0]          o_evt_time,
  output logic [7:0]               o_evt_width,
  output logic [15:0]              o_dropped_cnt,
  output logic [2:0]               o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ARMED  = 3'd2,
    S_PULSE  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0]  MAX_W       = 8'(MAX_PULSE_CYCLES);

  state_t                     r_state, w_next;
  logic [15:0]                r_cnt;
  logic [TS_W-1:0]            r_ts;
  logic signed [DATA_W-1:0]   r_peak;
  logic [TS_W-1:0]            r_peak_ts;
  logic [7:0]                 r_width;

  logic                       r_evt_valid;
  logic signed [DATA_W-1:0]   r_evt_peak;
  logic [TS_W-1:0]            r_evt_time;
  logic [7:0]                 r_evt_width;
  logic [15:0]                r_dropped;
  logic                       r_filt_rst_n;

  logic                       w_above;
  logic                       w_commit;
  logic                       w_free;
  logic signed [DATA_W-1:0]   w_c_peak;
  logic [TS_W-1:0]            w_c_ts;
  logic [7:0]                 w_c_width;

  assign w_above = i_filt_data > i_threshold;
  // Event register can take a new event if empty or being drained this cycle.
  assign w_free  = !r_evt_valid || i_evt_ready;

  // w_c_* is the pulse record as it stands after this cycle's sample; it
  // feeds both the pulse registers and, on pulse end, the event register.
  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_c_peak  = r_peak;
    w_c_ts    = r_peak_ts;
    w_c_width = r_width;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (!i_enable)                w_next = S_IDLE;
        else if (r_cnt == SETTLE_LAST) w_next = S_ARMED;
      end
      S_ARMED: begin
        w_c_peak  = i_filt_data;
        w_c_ts    = r_ts;
        w_c_width = 8'd1;
        if (!i_enable) w_next = S_IDLE;
        else if (w_above) begin
          // A width limit of one ends the pulse on its trigger sample.
          if (MAX_W == 8'd1) begin
            w_commit = 1'b1;
            w_next   = S_HOLD;
          end else begin
            w_next = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (!i_enable) w_next = S_IDLE;
        else if (w_above) begin
          w_c_width = r_width + 8'd1;
          // Strict compare: on ties the earliest sample keeps the timestamp.
          if (i_filt_data > r_peak) begin
            w_c_peak = i_filt_data;
            w_c_ts   = r_ts;
          end
          if (w_c_width == MAX_W) begin
            w_commit = 1'b1;
            w_next   = S_HOLD;
          end
        end else begin
          // Terminating sample is not part of the pulse.
          w_commit = 1'b1;
          w_next   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!i_enable)              w_next = S_IDLE;
        else if (r_cnt == HOLD_LAST) w_next = S_ARMED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_filt_rst_n <= 1'b0;
      r_cnt        <= '0;
      r_ts         <= '0;
    end else begin
      r_state      <= w_next;
      // Derived from the next state so the filter reset toggles on the same
      // edge as the state change and comes straight from a flop.
      r_filt_rst_n <= (w_next != S_IDLE);
      if (w_next != r_state)                          r_cnt <= '0;
      else if (r_state == S_SETTLE || r_state == S_HOLD) r_cnt <= r_cnt + 16'd1;
      if (r_state == S_IDLE && w_next == S_SETTLE)    r_ts <= '0;
      else if (r_state != S_IDLE)                     r_ts <= r_ts + TS_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_peak    <= '0;
      r_peak_ts <= '0;
      r_width   <= '0;
    end else if ((r_state == S_ARMED && w_above) || r_state == S_PULSE) begin
      r_peak    <= w_c_peak;
      r_peak_ts <= w_c_ts;
      r_width   <= w_c_width;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_peak  <= '0;
      r_evt_time  <= '0;
      r_evt_width <= '0;
      r_dropped   <= '0;
    end else if (w_commit) begin
      if (w_free) begin
        r_evt_valid <= 1'b1;
        r_evt_peak  <= w_c_peak;
        r_evt_time  <= w_c_ts;
        r_evt_width <= w_c_width;
      end else if (r_dropped != 16'hFFFF) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end else if (r_evt_valid && i_evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign o_state       = r_state;
  assign o_filt_rst_n  = r_filt_rst_n;
  assign o_evt_valid   = r_evt_valid;
  assign o_evt_peak    = r_evt_peak;
  assign o_evt_time    = r_evt_time;
  assign o_evt_width   = r_evt_width;
  assign o_dropped_cnt = r_dropped;

endmodule

// File: tb/tb_v6_filter_seq.sv
// Scoreboard bench for v6_filter_seq: expected events are queued as pulses
// are driven and checked as each one is transferred on the readout port.
module tb_v6_filter_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic signed [15:0] threshold;
  logic signed [15:0] filt_data;
  logic               filt_rst_n;
  logic               evt_valid;
  logic               evt_ready;
  logic signed [15:0] evt_peak;
  logic [31:0]        evt_time;
  logic [7:0]         evt_width;
  logic [15:0]        dropped_cnt;
  logic [2:0]         state;

  always #5 clk = ~clk;

  v6_filter_seq dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_threshold   (threshold),
    .i_filt_data   (filt_data),
    .o_filt_rst_n  (filt_rst_n),
    .o_evt_valid   (evt_valid),
    .i_evt_ready   (evt_ready),
    .o_evt_peak    (evt_peak),
    .o_evt_time    (evt_time),
    .o_evt_width   (evt_width),
    .o_dropped_cnt (dropped_cnt),
    .o_state       (state)
  );

  typedef struct {
    logic signed [15:0] peak;
    logic [31:0]        ts;
    logic [7:0]         width;
  } evt_t;

  evt_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   en_edge = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Timestamp the DUT will see for a sample driven now (consumed next edge).
  function automatic logic [31:0] ts_now();
    return 32'(cyc - en_edge);
  endfunction

  task automatic feed(input logic signed [15:0] d);
    filt_data = d;
    tick();
  endtask

  task automatic idle(input int n);
    filt_data = -16'sd1000;
    repeat (n) tick();
  endtask

  task automatic push(input logic signed [15:0] p, input logic [31:0] t, input logic [7:0] w);
    evt_t e;
    e.peak = p; e.ts = t; e.width = w;
    sb.push_back(e);
  endtask

  // Transfer happens at the next rising edge; inputs are stable at negedge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_evt", 64'(evt_peak), 64'hDEAD);
      end else begin
        evt_t e;
        e = sb.pop_front();
        chk("evt_peak", 64'(evt_peak), 64'(e.peak));
        chk("evt_time", 64'(evt_time), 64'(e.ts));
        chk("evt_width", 64'(evt_width), 64'(e.width));
      end
    end
  end

  initial begin
    logic [31:0] t;
    rst_n = 1'b0; enable = 1'b0; evt_ready = 1'b0;
    threshold = 16'sd100; filt_data = -16'sd1000;
    repeat (3) tick();
    chk("rst_state", 64'(state), 0);
    chk("rst_filt_rst_n", 64'(filt_rst_n), 0);
    chk("rst_valid", 64'(evt_valid), 0);
    chk("rst_fields", {evt_peak, evt_time, evt_width}, 0);
    chk("rst_dropped", 64'(dropped_cnt), 0);
    rst_n = 1'b1;

    // Enable at edge 10, ARMED after edge 74.
    while (cyc < 9) tick();
    enable = 1'b1; en_edge = cyc + 1;
    tick();
    chk("en_state_settle", 64'(state), 1);
    chk("en_filt_rst_n", 64'(filt_rst_n), 1);
    while (cyc < 73) tick();
    chk("settle_at_73", 64'(state), 1);
    tick();
    chk("armed_at_74", 64'(state), 2);

    // Basic pulse.
    evt_ready = 1'b1;
    feed(16'sd50);  chk("basic_no_trig", 64'(state), 2);
    feed(16'sd150); chk("basic_trig", 64'(state), 3);
    t = ts_now();
    feed(16'sd300); feed(16'sd300); feed(16'sd200);
    chk("basic_valid_early", 64'(evt_valid), 0);
    push(16'sd300, t, 8'd4);
    feed(16'sd90);
    chk("basic_valid_rise", 64'(evt_valid), 1);
    chk("basic_hold", 64'(state), 4);
    idle(20);

    // Signed threshold boundary.
    threshold = -16'sd20;
    feed(-16'sd20); chk("neg_eq1", 64'(state), 2);
    feed(-16'sd20); chk("neg_eq2", 64'(state), 2);
    push(-16'sd19, ts_now(), 8'd1);
    feed(-16'sd19); chk("neg_trig", 64'(state), 3);
    feed(-16'sd25);
    idle(20);
    threshold = 16'sd100;
    feed(16'sd100); chk("eq_no_trig", 64'(state), 2);
    idle(5);

    // Backpressure: second event dropped, first held.
    evt_ready = 1'b0;
    feed(16'sd200);
    t = ts_now();
    feed(16'sd400); feed(16'sd0);
    push(16'sd400, t, 8'd2);
    idle(30);
    feed(16'sd600); feed(16'sd0);
    chk("bp_dropped", 64'(dropped_cnt), 1);
    chk("bp_held_peak", 64'(evt_peak), 64'(16'sd400));
    chk("bp_held_time", 64'(evt_time), 64'(t));
    chk("bp_held_width", 64'(evt_width), 2);
    idle(20);
    evt_ready = 1'b1;
    tick();
    chk("bp_drained", 64'(evt_valid), 0);

    // Commit on the same cycle as a transfer.
    evt_ready = 1'b0;
    push(16'sd300, ts_now(), 8'd1);
    feed(16'sd300); feed(16'sd0);
    idle(20);
    push(16'sd500, ts_now(), 8'd1);
    feed(16'sd500);
    evt_ready = 1'b1;
    feed(16'sd0);
    chk("same_cyc_valid", 64'(evt_valid), 1);
    chk("same_cyc_peak", 64'(evt_peak), 64'(16'sd500));
    chk("same_cyc_dropped", 64'(dropped_cnt), 1);
    idle(20);

    // Width limit and immediate retrigger.
    for (int i = 0; i < 530; i++) begin
      if (i == 0 || i == 271) push(16'sd500, ts_now(), 8'd255);
      feed(16'sd500);
      if (i == 253) chk("wl_pulse_253", 64'(state), 3);
      if (i == 254) begin
        chk("wl_hold", 64'(state), 4);
        chk("wl_valid", 64'(evt_valid), 1);
      end
      if (i == 269) chk("wl_hold_end", 64'(state), 4);
      if (i == 270) chk("wl_armed", 64'(state), 2);
      if (i == 271) chk("wl_retrig", 64'(state), 3);
      if (i == 525) chk("wl_second_end", 64'(state), 4);
    end
    idle(20);

    // Disable mid-pulse with an event pending.
    evt_ready = 1'b0;
    push(16'sd300, ts_now(), 8'd1);
    feed(16'sd300); feed(16'sd0);
    idle(20);
    feed(16'sd700); chk("dis_pulse", 64'(state), 3);
    enable = 1'b0;
    feed(16'sd700);
    chk("dis_idle", 64'(state), 0);
    chk("dis_filt_rst_n", 64'(filt_rst_n), 0);
    chk("dis_kept_peak", 64'(evt_peak), 64'(16'sd300));
    chk("dis_kept_valid", 64'(evt_valid), 1);
    evt_ready = 1'b1;
    idle(1);
    chk("dis_drained", 64'(evt_valid), 0);
    idle(3);
    chk("dis_no_commit", 64'(evt_valid), 0);

    // Re-enable: timestamp restarts from zero.
    enable = 1'b1; en_edge = cyc + 1;
    tick();
    idle(64);
    chk("reen_armed", 64'(state), 2);
    push(16'sd250, ts_now(), 8'd1);
    feed(16'sd250); feed(16'sd0);
    idle(5);
    chk("sb_drain", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
